// File: rtl/zad1_pkg.sv
// Shared constants and helpers for the zad1 operand comparator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   ZAD1_WIDTH  - default operand width in bits
//   hdist_width - bits needed to hold a popcount of 0..width inclusive
package zad1_pkg;

  localparam int ZAD1_WIDTH = 8;

  // A popcount of a width-bit vector ranges 0..width, which is width+1
  // distinct values, so the count needs clog2(width+1) bits
  // (4 bits for width 8, since 8 itself must be representable).
  function automatic int hdist_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/zad1_popcount.sv
// Combinational population count of a WIDTH-bit vector.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the result follows vec_i continuously.
//
// Ports:
//   vec_i  [WIDTH-1:0]              vector to count
//   cnt_o  [hdist_width(WIDTH)-1:0] number of set bits in vec_i, 0..WIDTH
module zad1_popcount
  import zad1_pkg::*;
#(
  parameter int WIDTH = ZAD1_WIDTH
) (
  input  logic [WIDTH-1:0]              vec_i,
  output logic [hdist_width(WIDTH)-1:0] cnt_o
);

  localparam int CW = hdist_width(WIDTH);

  // Linear accumulation; the synthesis tool rebalances this into an adder
  // tree. The accumulator is CW bits wide, so the full count of WIDTH ones
  // fits without wrapping.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_o = cnt_o + CW'(vec_i[i]);
    end
  end

endmodule

// File: rtl/zad1.sv
// Registered unsigned comparator with Hamming distance between two operands.
// Latency: 1 cycle; every output is a flop, no combinational input-to-output path.
// Backpressure: none; operands are sampled every clock, one result per cycle.
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst    asynchronous active-high reset, clears every output while high
//   IN1    [WIDTH-1:0]  first unsigned operand
//   IN2    [WIDTH-1:0]  second unsigned operand
//   out    1 when IN1 == IN2 (registered)
//   gt     1 when IN1 >  IN2, unsigned (registered)
//   lt     1 when IN1 <  IN2, unsigned (registered)
//   hdist  [hdist_width(WIDTH)-1:0]  popcount(IN1 ^ IN2) (registered)
module zad1
  import zad1_pkg::*;
#(
  parameter int WIDTH = ZAD1_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              IN1,
  input  logic [WIDTH-1:0]              IN2,
  output logic                          out,
  output logic                          gt,
  output logic                          lt,
  output logic [hdist_width(WIDTH)-1:0] hdist
);

  localparam int HW = hdist_width(WIDTH);

  logic [WIDTH-1:0] diff;
  logic             eq_d;
  logic             gt_d;
  logic             lt_d;
  logic [HW-1:0]    hdist_d;

  logic             eq_q;
  logic             gt_q;
  logic             lt_q;
  logic [HW-1:0]    hdist_q;

  // Bitwise difference feeds both the equality flag and the distance count.
  assign diff = IN1 ^ IN2;

  zad1_popcount #(
    .WIDTH (WIDTH)
  ) u_popcount (
    .vec_i (diff),
    .cnt_o (hdist_d)
  );

  // Equality is taken from the XOR vector so that out and hdist == 0 can
  // never disagree. lt is derived as "neither equal nor greater", which
  // makes the three flags one-hot by construction and saves a comparator.
  assign eq_d = (diff == '0);
  assign gt_d = (IN1 > IN2);
  assign lt_d = ~eq_d & ~gt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      hdist_q <= '0;
    end else begin
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      hdist_q <= hdist_d;
    end
  end

  assign out   = eq_q;
  assign gt    = gt_q;
  assign lt    = lt_q;
  assign hdist = hdist_q;

endmodule

// File: tb/tb_zad1.sv
// Self-checking bench for zad1: directed steps followed by random back-to-back
// operands, compared against a plain-arithmetic model of the operand pair
// sampled at the previous rising edge.
module tb_zad1;

  localparam int W  = 8;
  localparam int HW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in1;
  logic [W-1:0]  in2;
  logic          out_s;
  logic          gt_s;
  logic          lt_s;
  logic [HW-1:0] hd_s;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  zad1 #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .IN1   (in1),
    .IN2   (in2),
    .out   (out_s),
    .gt    (gt_s),
    .lt    (lt_s),
    .hdist (hd_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference: what the outputs must show for operand pair (a, b).
  task automatic check_pair(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int exp_eq;
    int exp_gt;
    int exp_lt;
    int exp_hd;
    exp_eq = (a == b) ? 1 : 0;
    exp_gt = (a > b) ? 1 : 0;
    exp_lt = (a < b) ? 1 : 0;
    exp_hd = $countones(a ^ b);
    check({tag, ".out"},   32'(out_s), 32'(exp_eq));
    check({tag, ".gt"},    32'(gt_s),  32'(exp_gt));
    check({tag, ".lt"},    32'(lt_s),  32'(exp_lt));
    check({tag, ".hdist"}, 32'(hd_s),  32'(exp_hd));
    check({tag, ".onehot"}, 32'(out_s) + 32'(gt_s) + 32'(lt_s), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".out"},   32'(out_s), 32'd0);
    check({tag, ".gt"},    32'(gt_s),  32'd0);
    check({tag, ".lt"},    32'(lt_s),  32'd0);
    check({tag, ".hdist"}, 32'(hd_s),  32'd0);
  endtask

  // Drive one operand pair at the falling edge, check it after the next
  // rising edge. Called repeatedly this gives a new pair every cycle.
  task automatic apply(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in1 = a;
    in2 = b;
    @(posedge clk);
    #1;
    check_pair(tag, a, b);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst = 1'b1;
    in1 = '0;
    in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");

    @(negedge clk);
    rst = 1'b0;

    apply("eq_00_00", 8'h00, 8'h00);
    apply("lt_00_0a", 8'h00, 8'h0A);
    apply("lt_01_10", 8'h01, 8'h10);
    apply("eq_11_11", 8'h11, 8'h11);
    apply("gt_ff_00", 8'hFF, 8'h00);
    apply("lt_00_ff", 8'h00, 8'hFF);
    apply("hd8_aa_55", 8'hAA, 8'h55);
    apply("gt_81_80", 8'h81, 8'h80);

    // Inputs change mid-cycle; outputs must still show the previous pair.
    @(negedge clk);
    in1 = 8'h3C;
    in2 = 8'h3C;
    #1;
    check_pair("hold", 8'h81, 8'h80);
    @(posedge clk);
    #1;
    check_pair("eq_3c_3c", 8'h3C, 8'h3C);

    // Mid-stream reset while out = 1, asserted away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    @(posedge clk);
    #1;
    check_zero("rst_held");
    @(negedge clk);
    rst = 1'b0;
    in1 = 8'h05;
    in2 = 8'h09;
    @(posedge clk);
    #1;
    check_pair("post_rst", 8'h05, 8'h09);

    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ra;
      else if ($urandom_range(0, 7) == 0) rb = ~ra;
      apply("rand", ra, rb);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/zad1.md
ZAD1 -- requirements
Module: zad1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port IN1, input, WIDTH bits: first unsigned operand.
REQ-005 The block SHALL have port IN2, input, WIDTH bits: second unsigned operand.
REQ-006 The block SHALL have port out, output, 1 bit: registered equality flag, 1 when IN1 == IN2.
REQ-007 The block SHALL have port gt, output, 1 bit: registered flag, 1 when IN1 > IN2, unsigned.
REQ-008 The block SHALL have port lt, output, 1 bit: registered flag, 1 when IN1 < IN2, unsigned.
REQ-009 The block SHALL have port hdist, output, clog2(WIDTH+1) bits (4 for WIDTH=8): registered Hamming distance, the popcount of IN1 XOR IN2.

Function
REQ-010 Outputs SHALL reflect the IN1/IN2 values sampled at the previous rising clk edge; latency is exactly 1 cycle, with no combinational input-to-output path.
REQ-011 Exactly one of out, gt and lt SHALL be 1 in every cycle after the first post-reset clock edge.
REQ-012 The comparison SHALL be unsigned, over all WIDTH bits.
- IN1 = all-ones and IN2 = 0 -> gt = 1.
- IN1 = 0 and IN2 = all-ones -> lt = 1.
REQ-013 out SHALL be 1 if and only if hdist == 0.
REQ-014 hdist SHALL span 0..WIDTH without overflow; WIDTH (8) occurs when IN2 == ~IN1.
REQ-015 Inputs are sampled every cycle; there is no enable and no handshake.
REQ-016 Operands changing every cycle SHALL produce one result per cycle, each result tracking its own sampled operand pair.

Reset
REQ-017 While rst = 1, the outputs SHALL be: out = 0, gt = 0, lt = 0, hdist = 0.
- Applied asynchronously, independent of clk.
REQ-018 The first valid result SHALL appear at the first rising clk edge after rst deasserts.
REQ-019 Reset asserted mid-operation SHALL clear all outputs immediately; no prior result is retained.

Structure
REQ-020 A shared package zad1_pkg SHALL hold the WIDTH default constant and a function computing the hdist width, clog2(WIDTH+1).
REQ-021 The popcount SHALL be a combinational sub-module, zad1_popcount, with input WIDTH bits and output clog2(WIDTH+1) bits.
REQ-022 The top level SHALL contain the XOR, the magnitude compare and the output registers.

Verification
REQ-023 IN1 = 8'h00, IN2 = 8'h00 -> next cycle: out = 1, gt = 0, lt = 0, hdist = 0.
REQ-024 IN1 = 8'h00, IN2 = 8'h0A -> next cycle: out = 0, lt = 1, hdist = 2.
REQ-025 IN1 = 8'h01, IN2 = 8'h10 -> next cycle: out = 0, lt = 1, hdist = 2.
REQ-026 IN1 = 8'h11, IN2 = 8'h11 -> next cycle: out = 1, hdist = 0.
- Then IN1 = 8'hFF, IN2 = 8'h00 -> next cycle: gt = 1, hdist = 8.
REQ-027 Assert rst mid-stream while out = 1 -> all outputs 0 immediately, without waiting for clk.
- Deassert rst -> valid result at the following edge.
REQ-028 Random back-to-back operand pairs for 1000 cycles -> each output equals the reference model of the previous cycle's inputs, and exactly one of out, gt, lt is 1 every cycle.
